// File: rtl/pe_noc_pkg.sv
// Shared NoC definitions for the memory->PE packet path: field widths,
// node addresses, opcode and error-code encodings, packet and spike-entry layouts.
package pe_noc_pkg;

  localparam int ADDR_W = 4;
  localparam int OP_W   = 2;
  localparam int PKT_W  = 39;
  localparam int SPK_W  = 5;
  localparam int FILT_W = 24;
  localparam int BYTE_W = 8;
  localparam int PAY_W  = PKT_W - OP_W - 2 * ADDR_W;

  localparam logic [ADDR_W-1:0] ADDR_MEM = 4'd8;
  localparam logic [ADDR_W-1:0] ADDR_PE0 = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_PE1 = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_PE2 = 4'd0;

  typedef enum logic [OP_W-1:0] {
    OP_SPK_FILT = 2'd0,
    OP_SPK      = 2'd1
  } op_e;

  typedef enum logic [1:0] {
    ERR_ADDR    = 2'd0,
    ERR_OP      = 2'd1,
    ERR_NO_FILT = 2'd2
  } err_e;

  // First declared field lands in the MSBs, so payload occupies [38:10].
  typedef struct packed {
    logic [PAY_W-1:0]  payload;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dest;
  } noc_pkt_t;

  typedef struct packed {
    logic             first;
    logic [SPK_W-1:0] row;
  } spk_ent_t;

endpackage

// File: rtl/pe_spike_fifo.sv
// Show-ahead spike-row FIFO. Head entry is always visible on rdata;
// push is ignored when full and pop is ignored when empty.
module pe_spike_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rd_ptr];

  // Storage write; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
      r_wr_ptr        <= r_wr_ptr + 1'b1;
    end
  end

  // Read pointer and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pe_packet_decoder.sv
// PE-side receiver for memory->PE NoC packets. Filters on destination and
// source, decodes the opcode, latches the filter row and queues spike rows.
// Optional feature: define PE_PKT_STATS_EN to add pkt_cnt/drop_cnt counters.
//
// state   | meaning
// NO_FILT | no filter row loaded since reset; spike-only packets are errors
// ARMED   | filter row valid; spike-only packets are queued
module pe_packet_decoder
  import pe_noc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PE_ADDR   = 4'd4,
  parameter logic [ADDR_W-1:0] MEM_ADDR  = 4'd8,
  parameter int                SPK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PKT_W-1:0]  in_packet,
  output logic [FILT_W-1:0] filt_row,
  output logic              filt_load,
  output logic              spk_valid,
  input  logic              spk_ready,
  output logic [SPK_W-1:0]  spk_row,
  output logic              spk_first,
  output logic              err_pulse,
  output logic [1:0]        err_code
`ifdef PE_PKT_STATS_EN
  ,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam logic [0:0] NO_FILT = 1'b0;
  localparam logic [0:0] ARMED   = 1'b1;

  logic [0:0]        r_state;
  logic              r_rdy_en;
  logic [FILT_W-1:0] r_filt_row;
  logic              r_filt_load;
  logic              r_err_pulse;
  logic [1:0]        r_err_code;

  noc_pkt_t          w_pkt;
  spk_ent_t          w_push_ent;
  spk_ent_t          w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_addr_bad;
  logic              w_op_bad;
  logic              w_no_filt;
  logic              w_drop;
  logic              w_push;
  logic              w_is_filt;

  assign w_pkt      = noc_pkt_t'(in_packet);
  assign in_ready   = r_rdy_en && !w_full;
  assign w_accept   = in_valid && in_ready;
  assign w_addr_bad = (w_pkt.dest != PE_ADDR) || (w_pkt.src != MEM_ADDR);
  assign w_op_bad   = w_pkt.op[1];
  assign w_is_filt  = (w_pkt.op == OP_SPK_FILT);
  assign w_no_filt  = (w_pkt.op == OP_SPK) && (r_state == NO_FILT);
  assign w_drop     = w_accept && (w_addr_bad || w_op_bad || w_no_filt);
  assign w_push     = w_accept && !w_drop;

  // op0 carries its spike row above the filter bytes; op1 carries it in the low bits.
  assign w_push_ent.first = w_is_filt;
  assign w_push_ent.row   = w_is_filt ? w_pkt.payload[FILT_W +: SPK_W]
                                      : w_pkt.payload[SPK_W-1:0];

  pe_spike_fifo #(
    .DEPTH (SPK_DEPTH),
    .WIDTH (SPK_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (w_push_ent),
    .pop   (spk_ready),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Mask the head so stale storage never shows while the queue is empty.
  assign spk_valid = !w_empty;
  assign spk_row   = w_empty ? '0 : w_head.row;
  assign spk_first = !w_empty && w_head.first;
  assign filt_row  = r_filt_row;
  assign filt_load = r_filt_load;
  assign err_pulse = r_err_pulse;
  assign err_code  = r_err_code;

  // Hold off acceptance until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  // Filter latch and window state; any valid op0 (re)arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= NO_FILT;
      r_filt_row  <= '0;
      r_filt_load <= 1'b0;
    end else begin
      r_filt_load <= 1'b0;
      if (w_push && w_is_filt) begin
        r_state     <= ARMED;
        r_filt_row  <= w_pkt.payload[FILT_W-1:0];
        r_filt_load <= 1'b1;
      end
    end
  end

  // Drop reporting; address faults take priority over opcode faults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pulse <= 1'b0;
      r_err_code  <= ERR_ADDR;
    end else begin
      r_err_pulse <= w_drop;
      if (w_drop) begin
        if (w_addr_bad)    r_err_code <= ERR_ADDR;
        else if (w_op_bad) r_err_code <= ERR_OP;
        else               r_err_code <= ERR_NO_FILT;
      end
    end
  end

`ifdef PE_PKT_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_drop_cnt;

  // Saturating traffic counters; dropped packets count as accepted too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept && (r_pkt_cnt != 16'hFFFF))  r_pkt_cnt  <= r_pkt_cnt + 16'd1;
      if (w_drop && (r_drop_cnt != 16'hFFFF))   r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule
